pnode_tag_collector: RTL and testbench
======================================

Name: pnode_tag_collector

Overview:
- Collects per-node match results (10-bit tags) from the `ncount` matchblock wrappers.
- Serves as the responder on each node's data_out/data_valid/data_ack handshake.
- Arbitrates round-robin into a buffered FIFO and emits a single valid/ready tag stream toward the ethpack tag input.
- Runs in the 312.5 MHz processing domain.

Parameters:
- NCOUNT, 8, number of processing nodes.
- TAG_W, 10, tag width per node.
- DEPTH, 16, output FIFO entries; power of two, ≥ 4.
- CH_W, 3, width of the node-index channel field; equals log2(NCOUNT).

Ports:
- clock  in  1  processing clock; all logic is single-clock on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- node_data  in  NCOUNT*TAG_W  node i's tag occupies bits [i*TAG_W +: TAG_W].
- node_valid  in  NCOUNT  node i holds a tag; data is stable while valid is high.
- node_ack  out  NCOUNT  one-cycle registered pulse meaning node i's tag was taken.
- tag_data  out  TAG_W  head-of-FIFO tag.
- tag_channel  out  CH_W  index of the node that produced tag_data.
- tag_valid  out  1  FIFO is non-empty.
- tag_ready  in  1  downstream accepts when tag_valid && tag_ready.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - node_ack=0, tag_valid=0, fifo_level=0.
  - tag_data=0, tag_channel=0.
  - Round-robin pointer=0; hold-off mask cleared.
- Eligibility: node i is eligible in a cycle when all of the following hold:
  - node_valid[i]=1;
  - hold-off bit i=0;
  - fifo_level < DEPTH.
  A push is never accepted while full, even if a pop occurs in the same cycle.
- Arbitration:
  - At most one grant per cycle.
  - Search starts at the pointer and wraps modulo NCOUNT.
  - The first eligible node wins.
  - After grant k, the pointer becomes (k+1) mod NCOUNT. With no grant, the pointer is unchanged.
- Capture at cycle N (grant to node k):
  - {k, node_data[k]} is written to the FIFO at the end of N.
  - node_ack[k]=1 during N+1 only.
  - Hold-off bit k=1 during N+1 only, so node k is ineligible in N+1. This gives the node one cycle to react to the ack.
  - Node k may be granted again from N+2 if it presents a new valid.
- FIFO:
  - Show-ahead: tag_valid/tag_data/tag_channel reflect the head entry.
  - Latency: a tag captured in N appears on the outputs in N+1 when the FIFO was empty, so input-to-output latency is 1 cycle.
  - Pop on tag_valid && tag_ready.
  - Push and pop in the same cycle (not full) leave the level unchanged.
  - Outputs are stable while tag_valid && !tag_ready.
  - Pointers wrap modulo DEPTH.
  - fifo_level updates registered, on the same edge as the push/pop.
- Back-pressure: while full, no grants and no acks are issued. Nodes keep valid high and data stable; nothing is dropped.
- node_ack is never asserted for a node that was not granted in the previous cycle. At most one ack bit is high per cycle.
- Reset mid-operation:
  - FIFO contents are discarded and pending acks are cleared.
  - Nodes still holding valid are re-granted after reset release, starting the search from node 0.
- Sustained throughput: one tag per cycle when ≥2 nodes are valid and downstream is ready. A single continuously-valid node achieves one tag per 2 cycles.

Test Plan:
- Single node: node 3 valid with tag 0x155, tag_ready=1.
  - Required: node_ack[3] pulses in N+1.
  - Required: tag_valid=1, tag_data=0x155, tag_channel=3 in N+1; fifo_level returns to 0 after the pop.
- Fairness: all 8 nodes valid continuously (tag = 0x100+i, re-presented after each ack), tag_ready=1.
  - Required output channel sequence: 0,1,2,…,7,0,1,…
  - Required: one tag per cycle with no gaps after the first.
- Full back-pressure: DEPTH=16, tag_ready=0, all nodes valid.
  - Required: exactly 16 acks, then fifo_level=16 and no further acks.
  - Raising tag_ready for 1 cycle: one pop in that cycle, no push; fifo_level=15.
  - Next cycle: one push, level back to 16.
- Hold-off: only node 5 valid continuously with tag 0x2AA.
  - Required: grants on alternating cycles only.
  - Required: node_ack[5] never high in two consecutive cycles.
- Output stall: 3 tags queued, tag_ready=0 for 10 cycles.
  - Required: tag_data/tag_channel constant during the stall.
  - Required: 3 tags delivered in capture order once ready rises.
- Async reset: assert reset mid-burst with fifo_level=7.
  - Required: tag_valid, node_ack and fifo_level drop to 0 immediately, without waiting for a clock edge.
  - Required: after release, the first grant goes to the lowest-indexed valid node.

Source files
------------

// File: rtl/pnode_tag_collector_if.sv
// Bundle of the per-node tag handshake and the collected tag stream.
// The slave modport is the collector; the master modport is the node/downstream side.
interface pnode_tag_collector_if #(
  parameter int NCOUNT = 8,
  parameter int TAG_W  = 10,
  parameter int DEPTH  = 16,
  parameter int CH_W   = 3
);
  logic [NCOUNT*TAG_W-1:0]   node_data;
  logic [NCOUNT-1:0]         node_valid;
  logic [NCOUNT-1:0]         node_ack;
  logic [TAG_W-1:0]          tag_data;
  logic [CH_W-1:0]           tag_channel;
  logic                      tag_valid;
  logic                      tag_ready;
  logic [$clog2(DEPTH):0]    fifo_level;

  modport master (
    output node_data, node_valid, tag_ready,
    input  node_ack, tag_data, tag_channel, tag_valid, fifo_level
  );

  modport slave (
    input  node_data, node_valid, tag_ready,
    output node_ack, tag_data, tag_channel, tag_valid, fifo_level
  );
endinterface

// File: rtl/pnode_tag_collector.sv
// Round-robin collector of per-node match tags into a show-ahead FIFO.
// A granted node is acked one cycle later and is held off for that same cycle.
module pnode_tag_collector #(
  parameter int NCOUNT = 8,
  parameter int TAG_W  = 10,
  parameter int DEPTH  = 16,
  parameter int CH_W   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  pnode_tag_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CH_W + TAG_W;

  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [CH_W-1:0]   rr_ptr_r;
  // The ack register doubles as the hold-off mask: a node acked this cycle is not eligible.
  logic [NCOUNT-1:0] ack_r;

  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic [NCOUNT-1:0] eligible_s;
  logic              grant_s;
  logic [CH_W-1:0]   grant_idx_s;
  logic [CH_W-1:0]   cand_s;
  logic [TAG_W-1:0]  grant_tag_s;

  assign full_s      = (level_r == LW'(DEPTH));
  assign eligible_s  = full_s ? {NCOUNT{1'b0}} : (bus.node_valid & ~ack_r);
  assign pop_s       = (level_r != {LW{1'b0}}) && bus.tag_ready;
  assign push_s      = grant_s;
  assign grant_tag_s = bus.node_data[int'(grant_idx_s)*TAG_W +: TAG_W];

  // Round-robin search from the pointer; first eligible node wins.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = {CH_W{1'b0}};
    cand_s      = {CH_W{1'b0}};
    for (int i = 0; i < NCOUNT; i++) begin
      cand_s      = rr_ptr_r + CH_W'(i);
      grant_idx_s = (!grant_s && eligible_s[cand_s]) ? cand_s : grant_idx_s;
      grant_s     = grant_s | eligible_s[cand_s];
    end
  end

  // Arbiter pointer, ack/hold-off, FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= {CH_W{1'b0}};
      ack_r    <= {NCOUNT{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      ack_r <= grant_s ? ({{(NCOUNT-1){1'b0}}, 1'b1} << grant_idx_s) : {NCOUNT{1'b0}};
      if (grant_s) begin
        rr_ptr_r <= grant_idx_s + {{(CH_W-1){1'b0}}, 1'b1};
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage; cleared so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {grant_idx_s, grant_tag_s};
      end
    end
  end

  assign bus.node_ack                     = ack_r;
  assign bus.tag_valid                    = (level_r != {LW{1'b0}});
  assign {bus.tag_channel, bus.tag_data}  = mem_r[rd_ptr_r];
  assign bus.fifo_level                   = level_r;
endmodule

// File: tb/tb_pnode_tag_collector.sv
// Randomized scoreboard bench for pnode_tag_collector with a queue-based reference model.
module tb_pnode_tag_collector;
  localparam int NCOUNT = 8;
  localparam int TAG_W  = 10;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 3;

  localparam int M_HOLD    = 0;  // acked node re-presents the same tag
  localparam int M_ONESHOT = 1;  // acked node drops valid
  localparam int M_RANDOM  = 2;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pnode_tag_collector_if #(.NCOUNT(NCOUNT), .TAG_W(TAG_W), .DEPTH(DEPTH), .CH_W(CH_W)) bus();

  pnode_tag_collector #(.NCOUNT(NCOUNT), .TAG_W(TAG_W), .DEPTH(DEPTH), .CH_W(CH_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int pass_cnt = 0;
  int check_cnt = 0;
  int ack_seen = 0;

  exp_t              exp_q[$];
  int                m_ptr;
  int                m_level;
  logic [NCOUNT-1:0] m_ack;
  logic [NCOUNT-1:0] node_v;
  logic [TAG_W-1:0]  node_tag [NCOUNT];
  logic              ready_v;
  logic [NCOUNT-1:0] prev_ack = '0;

  task automatic check(input string name, input int act, input int want);
    check_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
  endtask

  task automatic drive();
    bus.node_valid = node_v;
    for (int i = 0; i < NCOUNT; i++) bus.node_data[i*TAG_W +: TAG_W] = node_tag[i];
    bus.tag_ready = ready_v;
  endtask

  // Reference model: one cycle of the collector, from the arbitration and FIFO rules.
  task automatic model_step();
    logic [NCOUNT-1:0] elig;
    int g;
    bit pop;
    elig = (m_level >= DEPTH) ? '0 : (node_v & ~m_ack);
    g = -1;
    for (int j = 0; j < NCOUNT; j++) begin
      int c;
      c = (m_ptr + j) % NCOUNT;
      if (g < 0 && elig[c]) g = c;
    end
    pop = (m_level > 0) && ready_v;
    m_ack = '0;
    if (g >= 0) begin
      exp_q.push_back('{ch: CH_W'(g), tag: node_tag[g]});
      m_ptr = (g + 1) % NCOUNT;
      m_ack[g] = 1'b1;
      m_level++;
    end
    if (pop) m_level--;
  endtask

  task automatic sample_phase();
    @(negedge clock);
    check("node_ack", bus.node_ack, m_ack);
    check("fifo_level", bus.fifo_level, m_level);
    check("tag_valid", bus.tag_valid, int'(m_level != 0));
    check("ack_onehot", int'($countones(bus.node_ack) <= 1), 1);
    check("ack_back_to_back", int'((bus.node_ack & prev_ack) != '0), 0);
    ack_seen += $countones(bus.node_ack);
    prev_ack = bus.node_ack;
    #1;
  endtask

  task automatic drive_phase(input int mode, input int ready_pct);
    for (int i = 0; i < NCOUNT; i++) begin
      if (m_ack[i]) begin
        if (mode == M_ONESHOT) node_v[i] = 1'b0;
        else if (mode == M_RANDOM) begin
          if ($urandom_range(0, 1) == 0) node_v[i] = 1'b0;
          else node_tag[i] = TAG_W'($urandom);
        end
      end else if (mode == M_RANDOM && !node_v[i] && $urandom_range(0, 99) < 30) begin
        node_v[i] = 1'b1;
        node_tag[i] = TAG_W'($urandom);
      end
    end
    ready_v = ($urandom_range(0, 99) < ready_pct);
    drive();
    model_step();
  endtask

  task automatic cycle(input int mode, input int ready_pct);
    sample_phase();
    drive_phase(mode, ready_pct);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  logic              stall_p = 1'b0;
  logic [TAG_W-1:0]  stall_tag;
  logic [CH_W-1:0]   stall_ch;
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          check("stall_tag_data", bus.tag_data, stall_tag);
          check("stall_tag_channel", bus.tag_channel, stall_ch);
        end
        if (bus.tag_valid && bus.tag_ready) begin
          check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_channel", bus.tag_channel, e.ch);
            check("out_tag", bus.tag_data, e.tag);
          end
        end
        stall_p   = bus.tag_valid && !bus.tag_ready;
        stall_tag = bus.tag_data;
        stall_ch  = bus.tag_channel;
      end
    end
  end

  initial begin
    reset = 1'b1;
    node_v = '0;
    ready_v = 1'b0;
    for (int i = 0; i < NCOUNT; i++) node_tag[i] = '0;
    drive();
    m_ptr = 0; m_level = 0; m_ack = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ack", bus.node_ack, 0);
    check("reset_level", bus.fifo_level, 0);
    check("reset_valid", bus.tag_valid, 0);
    check("reset_tag_data", bus.tag_data, 0);
    check("reset_channel", bus.tag_channel, 0);
    #1 reset = 1'b0;
    ready_v = 1'b1;
    drive();
    model_step();

    // Single node 3 with tag 0x155
    sample_phase();
    node_v = 8'b0000_1000;
    node_tag[3] = 10'h155;
    drive_phase(M_ONESHOT, 100);
    repeat (6) cycle(M_ONESHOT, 100);

    // Fairness: all nodes continuously valid
    sample_phase();
    node_v = 8'hFF;
    for (int i = 0; i < NCOUNT; i++) node_tag[i] = TAG_W'(10'h100 + i);
    drive_phase(M_HOLD, 100);
    repeat (30) cycle(M_HOLD, 100);
    repeat (15) cycle(M_ONESHOT, 100);

    // Hold-off: only node 5
    sample_phase();
    node_v = 8'b0010_0000;
    node_tag[5] = 10'h2AA;
    drive_phase(M_HOLD, 100);
    repeat (20) cycle(M_HOLD, 100);
    repeat (5) cycle(M_ONESHOT, 100);

    // Full back-pressure
    ack_seen = 0;
    sample_phase();
    node_v = 8'hFF;
    for (int i = 0; i < NCOUNT; i++) node_tag[i] = TAG_W'(10'h100 + i);
    drive_phase(M_HOLD, 0);
    repeat (19) cycle(M_HOLD, 0);
    check("bp_ack_count", ack_seen, 16);
    check("bp_level_full", bus.fifo_level, 16);
    cycle(M_HOLD, 100);
    cycle(M_HOLD, 0);
    check("bp_level_after_pop", bus.fifo_level, 15);
    check("bp_no_ack_after_pop", bus.node_ack, 0);
    cycle(M_HOLD, 0);
    check("bp_level_refill", bus.fifo_level, 16);
    repeat (40) cycle(M_ONESHOT, 100);

    // Output stall with three queued tags
    sample_phase();
    node_v = 8'b0000_0111;
    for (int i = 0; i < 3; i++) node_tag[i] = TAG_W'($urandom);
    drive_phase(M_ONESHOT, 0);
    repeat (12) cycle(M_ONESHOT, 0);
    repeat (6) cycle(M_ONESHOT, 100);

    // Random traffic
    repeat (300) cycle(M_RANDOM, 70);
    repeat (100) cycle(M_RANDOM, 100);
    repeat (40) cycle(M_ONESHOT, 100);

    // Asynchronous reset with seven tags queued
    sample_phase();
    node_v = 8'b0110_0100;
    for (int i = 0; i < NCOUNT; i++) node_tag[i] = TAG_W'($urandom);
    drive_phase(M_HOLD, 0);
    for (int k = 0; k < 20 && m_level != 7; k++) cycle(M_HOLD, 0);
    sample_phase();
    check("pre_reset_level", bus.fifo_level, 7);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", bus.tag_valid, 0);
    check("async_rst_ack", bus.node_ack, 0);
    check("async_rst_level", bus.fifo_level, 0);
    check("async_rst_tag_data", bus.tag_data, 0);
    exp_q.delete();
    m_ptr = 0; m_level = 0; m_ack = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    ready_v = 1'b1;
    drive();
    model_step();
    check("post_reset_first_grant", exp_q[0].ch, 2);
    repeat (8) cycle(M_HOLD, 100);
    repeat (30) cycle(M_ONESHOT, 100);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
